eth_phy_10g_tx_gearbox: RTL and testbench



---
 rtl/eth_phy_10g_tx_gearbox.sv | 80 ++++++++
 tb/tb_eth_phy_10g_tx_gearbox.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/eth_phy_10g_tx_gearbox.sv
// rtl/eth_phy_10g_tx_gearbox.sv - 66b to 32b TX gearbox; optional ETH_PHY_TX_GBX_BIT_REVERSE_EN for MSB-first output
module eth_phy_10g_tx_gearbox #(
   parameter int DATA_WIDTH = 64,
   parameter int HDR_WIDTH  = 2,
   parameter int OUT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_tx_data,
   input  logic [HDR_WIDTH-1:0]  s_tx_hdr,
   input  logic                  s_tx_valid,
   output logic                  s_tx_ready,
   output logic [OUT_WIDTH-1:0]  serdes_tx_data,
   output logic                  tx_underflow,
   output logic [5:0]            tx_gbx_seq
);

   // Pending line bits, LSB is the next bit to transmit
   logic [97:0] line_buf_q, line_buf_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [5:0]  seq_q, seq_d;
   logic [31:0] word_q, word_d;
   logic        underflow_q, underflow_d;

   logic [65:0] block;
   logic [97:0] merged;
   logic [6:0]  fill;

   assign s_tx_ready = (cnt_q < 7'd32);

   // Merge the incoming (or idle-substituted) block and split off the next word
   always_comb begin
      block       = s_tx_valid ? {s_tx_data, s_tx_hdr} : {64'h0, 2'b01};
      merged      = line_buf_q;
      fill        = cnt_q;
      underflow_d = 1'b0;
      if (s_tx_ready) begin
         merged      = line_buf_q | ({32'd0, block} << cnt_q);
         fill        = cnt_q + 7'd66;
         underflow_d = !s_tx_valid;
      end
      word_d     = merged[31:0];
      line_buf_d = merged >> 32;
      cnt_d      = fill - 7'd32;
      seq_d      = (seq_q == 6'd32) ? 6'd0 : seq_q + 6'd1;
   end

   // State registers; reset discards any partially sent block
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_buf_q  <= '0;
         cnt_q       <= '0;
         seq_q       <= '0;
         word_q      <= '0;
         underflow_q <= 1'b0;
      end else begin
         line_buf_q  <= line_buf_d;
         cnt_q       <= cnt_d;
         seq_q       <= seq_d;
         word_q      <= word_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef ETH_PHY_TX_GBX_BIT_REVERSE_EN
   // MSB-first transceivers: word bit 31 carries the first line bit
   always_comb begin
      serdes_tx_data = '0;
      for (int i = 0; i < 32; i++) begin
         serdes_tx_data[i] = word_q[31-i];
      end
   end
`else
   assign serdes_tx_data = word_q;
`endif

   assign tx_underflow = underflow_q;
   assign tx_gbx_seq   = seq_q;

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
// tb/tb_eth_phy_10g_tx_gearbox.sv - self-checking bench for eth_phy_10g_tx_gearbox
module tb_eth_phy_10g_tx_gearbox;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] s_tx_data = '0;
   logic [1:0]  s_tx_hdr = '0;
   logic        s_tx_valid = 1'b0;
   logic        s_tx_ready;
   logic [31:0] serdes_tx_data;
   logic        tx_underflow;
   logic [5:0]  tx_gbx_seq;

   eth_phy_10g_tx_gearbox dut (
      .clk            (clk),
      .rst            (rst),
      .s_tx_data      (s_tx_data),
      .s_tx_hdr       (s_tx_hdr),
      .s_tx_valid     (s_tx_valid),
      .s_tx_ready     (s_tx_ready),
      .serdes_tx_data (serdes_tx_data),
      .tx_underflow   (tx_underflow),
      .tx_gbx_seq     (tx_gbx_seq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: a plain queue of line bits awaiting transmission
   bit       mq[$];
   int       seq_exp;
   logic     got_ready;
   logic [31:0] got_word;

   typedef struct {
      logic        v;
      logic [63:0] d;
      logic [1:0]  h;
      logic        exp_ready;
      logic [31:0] exp_word;
   } vec_t;

   vec_t tbl[6];

   function automatic logic [31:0] line_to_port(input logic [31:0] w);
      logic [31:0] r;
`ifdef ETH_PHY_TX_GBX_BIT_REVERSE_EN
      for (int i = 0; i < 32; i++) r[i] = w[31-i];
`else
      r = w;
`endif
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_data", serdes_tx_data, 0);
      chk("rst_uf", tx_underflow, 0);
      chk("rst_seq", tx_gbx_seq, 0);
      chk("rst_ready", s_tx_ready, 1);
      mq.delete();
      seq_exp = 0;
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   // One clock cycle: drive, check ready, advance model, check registered outputs
   task automatic step(input logic v, input logic [63:0] d, input logic [1:0] h);
      logic [65:0] blk;
      logic [31:0] w;
      logic        uf;
      logic        rdy;
      s_tx_valid = v;
      s_tx_data  = d;
      s_tx_hdr   = h;
      #1;
      rdy = (mq.size() < 32);
      got_ready = s_tx_ready;
      chk("ready", s_tx_ready, rdy);
      uf = 1'b0;
      if (rdy) begin
         blk = v ? {d, h} : {64'h0, 2'b01};
         uf  = !v;
         for (int i = 0; i < 66; i++) mq.push_back(blk[i]);
      end
      for (int i = 0; i < 32; i++) w[i] = mq.pop_front();
      seq_exp = (seq_exp + 1) % 33;
      @(posedge clk);
      #1;
      got_word = serdes_tx_data;
      chk("word", serdes_tx_data, line_to_port(w));
      chk("underflow", tx_underflow, uf);
      chk("seq", tx_gbx_seq, seq_exp);
   endtask

   initial begin
      logic [63:0] cntr;
      int ones, wraps, ufs;

      tbl[0] = '{1'b1, 64'h1, 2'b01, 1'b1, 32'h0000_0005};
      tbl[1] = '{1'b1, 64'h2, 2'b01, 1'b0, 32'h0000_0000};
      tbl[2] = '{1'b1, 64'h2, 2'b01, 1'b1, 32'h0000_0024};
      tbl[3] = '{1'b1, 64'h3, 2'b01, 1'b0, 32'h0000_0000};
      tbl[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b1, 32'hFFFF_FFFE};
      tbl[5] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 32'hFFFF_FFFF};

      seq_exp = 0;
      repeat (2) @(posedge clk);

      // Table-driven fixed vectors
      for (int i = 0; i < 6; i++) begin
         if (i == 0 || i == 4) do_reset();
         step(tbl[i].v, tbl[i].d, tbl[i].h);
         chk("tbl_ready", got_ready, tbl[i].exp_ready);
         chk("tbl_word", got_word, line_to_port(tbl[i].exp_word));
      end

      // Incrementing stream: ready pattern and seq wrap alignment over 99 cycles
      do_reset();
      cntr = 64'h1; ones = 0; wraps = 0;
      for (int c = 0; c < 99; c++) begin
         logic acc;
         acc = (mq.size() < 32);
         step(1'b1, cntr, 2'b01);
         if (acc) cntr++;
         if (c < 33 && got_ready) ones++;
         if (tx_gbx_seq == 0) begin
            wraps++;
            chk("wrap_cnt0", mq.size(), 0);
         end
      end
      chk("ready_ones", ones, 16);
      chk("seq_wraps", wraps, 3);

      // Single underflow mid-stream
      ufs = 0;
      for (int c = 0; c < 10; c++) begin
         logic acc;
         acc = (mq.size() < 32);
         step(!(c == 4 && acc) && !(c == 5 && acc), cntr, 2'b01);
         if (acc) cntr++;
         if (tx_underflow) ufs++;
      end
      chk("uf_pulses", ufs, 1);

      // Asynchronous reset mid-block (cnt=36), then a fresh block starts at bit 0
      do_reset();
      step(1'b1, 64'h1, 2'b01);
      step(1'b1, 64'h0, 2'b01);
      step(1'b1, 64'h2, 2'b01);
      chk("cnt36", mq.size(), 36);
      do_reset();
      step(1'b1, 64'h1, 2'b01);
      chk("post_rst_word", got_word, line_to_port(32'h0000_0005));

      // Randomized stream against the model
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 9) != 0, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
